// File: rtl/ex_operand_forward_if.sv
// Interface bundling the decode, forwarding and write-back signals of ex_operand_forward.
// The master drives the pipeline inputs, and the slave (the datapath block) drives the operands and the write-back port.
interface ex_operand_forward_if #(
  parameter int DW  = 16,
  parameter int RAW = 5
);
  logic           stall;
  logic           dec_valid;
  logic [DW-1:0]  rf_A;
  logic [DW-1:0]  rf_B;
  logic [DW-1:0]  imm;
  logic           imm_sel;
  logic [1:0]     mux_sel_A;
  logic [1:0]     mux_sel_B;
  logic [DW-1:0]  alu_result;
  logic [DW-1:0]  dm_rdata;
  logic           mem_mux_sel_dm;
  logic [RAW-1:0] RW_dm;

  logic [DW-1:0]  op_a;
  logic [DW-1:0]  op_b;
  logic [DW-1:0]  store_data;
  logic           ex_valid;
  logic [DW-1:0]  wb_data;
  logic [RAW-1:0] wb_addr;
  logic           wb_en;

  modport master (
    output stall, dec_valid, rf_A, rf_B, imm, imm_sel, mux_sel_A, mux_sel_B,
           alu_result, dm_rdata, mem_mux_sel_dm, RW_dm,
    input  op_a, op_b, store_data, ex_valid, wb_data, wb_addr, wb_en
  );

  modport slave (
    input  stall, dec_valid, rf_A, rf_B, imm, imm_sel, mux_sel_A, mux_sel_B,
           alu_result, dm_rdata, mem_mux_sel_dm, RW_dm,
    output op_a, op_b, store_data, ex_valid, wb_data, wb_addr, wb_en
  );
endinterface

// File: rtl/ex_operand_forward.sv
// ID/EX, EX/DM and DM/WB data pipeline registers with EX-stage operand forwarding.
// Forward selects are trusted as given; no register-number comparison happens here.
module ex_operand_forward #(
  parameter int DW  = 16,
  parameter int RAW = 5
) (
  input logic                clk,
  input logic                reset,
  ex_operand_forward_if.slave bus
);

  logic           ex_valid_q;
  logic [DW-1:0]  rf_a_q;
  logic [DW-1:0]  rf_b_q;
  logic [DW-1:0]  imm_q;
  logic           imm_sel_q;
  logic [1:0]     sel_a_q;
  logic [1:0]     sel_b_q;
  logic [DW-1:0]  exdm_q;
  logic           dm_valid_q;
  logic [DW-1:0]  wb_data_q;
  logic [RAW-1:0] wb_addr_q;
  logic           wb_en_q;

  logic [DW-1:0]  fwd_a;
  logic [DW-1:0]  fwd_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      rf_a_q     <= '0;
      rf_b_q     <= '0;
      imm_q      <= '0;
      imm_sel_q  <= 1'b0;
      sel_a_q    <= 2'b00;
      sel_b_q    <= 2'b00;
      exdm_q     <= '0;
      dm_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_addr_q  <= '0;
      wb_en_q    <= 1'b0;
    end else begin
      // a stall inserts a bubble but keeps the fields, since decode is held upstream
      if (bus.stall) begin
        ex_valid_q <= 1'b0;
      end else begin
        ex_valid_q <= bus.dec_valid;
        rf_a_q     <= bus.rf_A;
        rf_b_q     <= bus.rf_B;
        imm_q      <= bus.imm;
        imm_sel_q  <= bus.imm_sel;
        sel_a_q    <= bus.mux_sel_A;
        sel_b_q    <= bus.mux_sel_B;
      end
      exdm_q     <= bus.alu_result;
      dm_valid_q <= ex_valid_q;
      wb_data_q  <= bus.mem_mux_sel_dm ? bus.dm_rdata : exdm_q;
      wb_addr_q  <= bus.RW_dm;
      wb_en_q    <= dm_valid_q && (bus.RW_dm != '0);
    end
  end

  always_comb begin
    fwd_a = rf_a_q;
    fwd_b = rf_b_q;
    case (sel_a_q)
      2'b01:   fwd_a = exdm_q;
      2'b10:   fwd_a = wb_data_q;
      default: fwd_a = rf_a_q;
    endcase
    case (sel_b_q)
      2'b01:   fwd_b = exdm_q;
      2'b10:   fwd_b = wb_data_q;
      default: fwd_b = rf_b_q;
    endcase
  end

  assign bus.op_a       = fwd_a;
  assign bus.store_data = fwd_b;
  assign bus.op_b       = imm_sel_q ? imm_q : fwd_b;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_en      = wb_en_q;

endmodule

// File: tb/tb_ex_operand_forward.sv
// Bench for ex_operand_forward: directed scenarios followed by random traffic, checked against a per-cycle history model.
module tb_ex_operand_forward;
  localparam int DW   = 16;
  localparam int RAW  = 5;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ex_operand_forward_if #(.DW(DW), .RAW(RAW)) bus ();

  ex_operand_forward #(.DW(DW), .RAW(RAW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Input history, indexed by the edge that sampled it
  logic           h_rst   [MAXC];
  logic           h_stall [MAXC];
  logic           h_dec   [MAXC];
  logic [DW-1:0]  h_ra    [MAXC];
  logic [DW-1:0]  h_rb    [MAXC];
  logic [DW-1:0]  h_imm   [MAXC];
  logic           h_isel  [MAXC];
  logic [1:0]     h_sa    [MAXC];
  logic [1:0]     h_sb    [MAXC];
  logic [DW-1:0]  h_alu   [MAXC];
  logic [DW-1:0]  h_rdata [MAXC];
  logic           h_msel  [MAXC];
  logic [RAW-1:0] h_rw    [MAXC];

  // Result captured from the ALU at edge k; this is what a 01 select sees after edge k.
  function automatic logic [DW-1:0] exdm_after(int k);
    if (k < 0 || h_rst[k]) return '0;
    return h_alu[k];
  endfunction

  // Write-back data after edge k: load data, or the ALU result from one edge earlier.
  function automatic logic [DW-1:0] wbd_after(int k);
    if (k < 0 || h_rst[k]) return '0;
    return h_msel[k] ? h_rdata[k] : exdm_after(k - 1);
  endfunction

  function automatic logic exv_after(int k);
    if (k < 0 || h_rst[k]) return 1'b0;
    return !h_stall[k] && h_dec[k];
  endfunction

  function automatic logic dmv_after(int k);
    if (k < 0 || h_rst[k]) return 1'b0;
    return exv_after(k - 1);
  endfunction

  function automatic logic wbe_after(int k);
    if (k < 0 || h_rst[k]) return 1'b0;
    return dmv_after(k - 1) && (h_rw[k] != '0);
  endfunction

  function automatic logic [RAW-1:0] wba_after(int k);
    if (k < 0 || h_rst[k]) return '0;
    return h_rw[k];
  endfunction

  // Edge whose decode fields occupy EX after edge k; -1 means the fields are cleared by reset.
  function automatic int dec_src(int k);
    for (int m = k; m >= 0; m--) begin
      if (h_rst[m]) return -1;
      if (!h_stall[m]) return m;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] fwd(logic [1:0] sel, logic [DW-1:0] rf, int k);
    if (sel == 2'b01) return exdm_after(k);
    if (sel == 2'b10) return wbd_after(k);
    return rf;
  endfunction

  function automatic logic [DW-1:0] exp_op_a(int k);
    int m = dec_src(k);
    if (m < 0) return '0;
    return fwd(h_sa[m], h_ra[m], k);
  endfunction

  function automatic logic [DW-1:0] exp_store(int k);
    int m = dec_src(k);
    if (m < 0) return '0;
    return fwd(h_sb[m], h_rb[m], k);
  endfunction

  function automatic logic [DW-1:0] exp_op_b(int k);
    int m = dec_src(k);
    if (m < 0) return '0;
    return h_isel[m] ? h_imm[m] : fwd(h_sb[m], h_rb[m], k);
  endfunction

  // Record the inputs, clock one edge, and settle 1 time unit later.
  task automatic tick();
    h_rst[cyc]   = reset;
    h_stall[cyc] = bus.stall;
    h_dec[cyc]   = bus.dec_valid;
    h_ra[cyc]    = bus.rf_A;
    h_rb[cyc]    = bus.rf_B;
    h_imm[cyc]   = bus.imm;
    h_isel[cyc]  = bus.imm_sel;
    h_sa[cyc]    = bus.mux_sel_A;
    h_sb[cyc]    = bus.mux_sel_B;
    h_alu[cyc]   = bus.alu_result;
    h_rdata[cyc] = bus.dm_rdata;
    h_msel[cyc]  = bus.mem_mux_sel_dm;
    h_rw[cyc]    = bus.RW_dm;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic randomize_inputs();
    bus.stall          = ($urandom_range(0, 5) == 0);
    bus.dec_valid      = ($urandom_range(0, 4) != 0);
    bus.rf_A           = DW'($urandom);
    bus.rf_B           = DW'($urandom);
    bus.imm            = DW'($urandom);
    bus.imm_sel        = 1'($urandom);
    bus.mux_sel_A      = 2'($urandom);
    bus.mux_sel_B      = 2'($urandom);
    bus.alu_result     = DW'($urandom);
    bus.dm_rdata       = DW'($urandom);
    bus.mem_mux_sel_dm = 1'($urandom);
    bus.RW_dm          = ($urandom_range(0, 5) == 0) ? '0 : RAW'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      bus.stall = 1'b0;
      bus.dec_valid = 1'b1;
      tick();
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.wb_en !== 1'b0 || bus.op_a !== '0 || bus.op_b !== '0 ||
        bus.store_data !== '0 || bus.wb_data !== '0 || bus.wb_addr !== '0) begin
      errors++;
      $display("FAIL reset_clear: ex_valid=%b wb_en=%b op_a=%h op_b=%h store=%h wb_data=%h wb_addr=%h, all required 0",
               bus.ex_valid, bus.wb_en, bus.op_a, bus.op_b, bus.store_data, bus.wb_data, bus.wb_addr);
    end
    for (int i = 0; i < 2; i++) begin
      bus.dec_valid = 1'b1;
      tick();
      checks++;
      if (bus.ex_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_ex_valid: got %b required 0", bus.ex_valid);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_no_fwd();
    bus.stall = 1'b0;
    bus.dec_valid = 1'b1;
    bus.rf_A = 16'h0012;
    bus.rf_B = 16'h0034;
    bus.mux_sel_A = 2'b00;
    bus.mux_sel_B = 2'b00;
    bus.imm_sel = 1'b0;
    tick();
    checks++;
    if (bus.op_a !== 16'h0012) begin
      errors++;
      $display("FAIL nofwd_op_a: got %h required 0012", bus.op_a);
    end
    checks++;
    if (bus.op_b !== 16'h0034) begin
      errors++;
      $display("FAIL nofwd_op_b: got %h required 0034", bus.op_b);
    end
    checks++;
    if (bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL nofwd_ex_valid: got %b required 1", bus.ex_valid);
    end
  endtask

  task automatic test_exdm_fwd();
    bus.alu_result = 16'h00AA;
    bus.mux_sel_A = 2'b01;
    bus.rf_A = 16'h1111;
    bus.dec_valid = 1'b1;
    tick();
    checks++;
    if (bus.op_a !== 16'h00AA) begin
      errors++;
      $display("FAIL exdm_fwd_op_a: got %h required 00aa", bus.op_a);
    end
  endtask

  task automatic test_dmwb_load();
    bus.mem_mux_sel_dm = 1'b1;
    bus.dm_rdata = 16'h5A5A;
    bus.mux_sel_A = 2'b00;
    bus.mux_sel_B = 2'b10;
    bus.imm_sel = 1'b1;
    bus.imm = 16'h0005;
    bus.rf_B = 16'h7777;
    tick();
    checks++;
    if (bus.op_b !== 16'h0005) begin
      errors++;
      $display("FAIL load_op_b: got %h required 0005", bus.op_b);
    end
    checks++;
    if (bus.store_data !== 16'h5A5A) begin
      errors++;
      $display("FAIL load_store_data: got %h required 5a5a", bus.store_data);
    end
    checks++;
    if (bus.wb_data !== 16'h5A5A) begin
      errors++;
      $display("FAIL load_wb_data: got %h required 5a5a", bus.wb_data);
    end
    bus.mem_mux_sel_dm = 1'b0;
    bus.imm_sel = 1'b0;
    bus.mux_sel_B = 2'b00;
  endtask

  task automatic test_stall();
    bus.RW_dm = 5'd7;
    bus.stall = 1'b0;
    bus.dec_valid = 1'b1;
    tick();
    bus.stall = 1'b1;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_bubble: ex_valid got %b required 0", bus.ex_valid);
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.wb_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_drain_wb_en: got %b required 1", bus.wb_en);
    end
  endtask

  task automatic test_r0_reset();
    bus.stall = 1'b0;
    bus.dec_valid = 1'b1;
    bus.RW_dm = '0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.wb_en !== 1'b0) begin
      errors++;
      $display("FAIL r0_no_write: wb_en got %b required 0", bus.wb_en);
    end
    bus.RW_dm = 5'd3;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.wb_en !== 1'b0 || bus.ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: wb_en=%b ex_valid=%b, both required 0", bus.wb_en, bus.ex_valid);
    end
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 39) == 0);
      tick();
      k = cyc - 1;
      checks++;
      if (bus.op_a !== exp_op_a(k) || bus.op_b !== exp_op_b(k) || bus.store_data !== exp_store(k) ||
          bus.ex_valid !== exv_after(k) || bus.wb_data !== wbd_after(k) ||
          bus.wb_addr !== wba_after(k) || bus.wb_en !== wbe_after(k)) begin
        errors++;
        $display("FAIL random_cycle%0d: got a=%h b=%h st=%h v=%b wd=%h wa=%h we=%b required a=%h b=%h st=%h v=%b wd=%h wa=%h we=%b",
                 k, bus.op_a, bus.op_b, bus.store_data, bus.ex_valid, bus.wb_data, bus.wb_addr, bus.wb_en,
                 exp_op_a(k), exp_op_b(k), exp_store(k), exv_after(k), wbd_after(k), wba_after(k), wbe_after(k));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.dec_valid = 1'b0;
    bus.rf_A = '0;
    bus.rf_B = '0;
    bus.imm = '0;
    bus.imm_sel = 1'b0;
    bus.mux_sel_A = 2'b00;
    bus.mux_sel_B = 2'b00;
    bus.alu_result = '0;
    bus.dm_rdata = '0;
    bus.mem_mux_sel_dm = 1'b0;
    bus.RW_dm = '0;
    tick();
    test_reset();
    test_no_fwd();
    test_exdm_fwd();
    test_dmwb_load();
    test_stall();
    test_r0_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
